// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } muldiv_state_t;

    localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN    = 32'h8000_0000;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 32-step radix-2 shift-add / restoring divide on magnitudes.
// Divide-by-zero and signed overflow resolve in one cycle; start is ignored while busy.
import muldiv_pkg::*;

module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [4:0]      rd_in,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            wb_en
);

    muldiv_state_t   state_q;
    muldiv_op_t      op_q;
    logic [4:0]      cnt_q;
    logic [4:0]      rd_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0] m_q;
    logic            a_neg_q, b_neg_q;
    logic [XLEN-1:0] result_q;

    muldiv_op_t      op_in;
    logic            sa, sb, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN:0]   mul_sum, div_r, div_diff;
    logic [2*XLEN-1:0] step, prod;
    logic [XLEN-1:0] quot, rem, fin_res;

    always_comb begin
        op_in    = muldiv_op_t'(funct3);
        sa       = (op_in == OP_MUL) || (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
                   (op_in == OP_DIV) || (op_in == OP_REM);
        sb       = (op_in == OP_MUL) || (op_in == OP_MULH) ||
                   (op_in == OP_DIV) || (op_in == OP_REM);
        a_neg    = sa && rs1_val[XLEN-1];
        b_neg    = sb && rs2_val[XLEN-1];
        a_mag    = a_neg ? -rs1_val : rs1_val;
        b_mag    = b_neg ? -rs2_val : rs2_val;
        div_zero = funct3[2] && (rs2_val == '0);
        div_ovf  = funct3[2] && !funct3[0] && (rs1_val == INT_MIN) && (rs2_val == '1);

        // Multiply: low half holds the multiplier and drains out as the product shifts in.
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, m_q} : '0);
        // Divide: high half is the partial remainder, low half dividend bits becoming quotient.
        div_r    = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff = div_r - {1'b0, m_q};
        if (state_q == S_MUL)
            step = {mul_sum, acc_q[XLEN-1:1]};
        else if (!div_diff[XLEN])
            step = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        else
            step = {div_r[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};

        prod = (a_neg_q ^ b_neg_q) ? -step : step;
        quot = (a_neg_q ^ b_neg_q) ? -step[XLEN-1:0] : step[XLEN-1:0];
        rem  = a_neg_q ? -step[2*XLEN-1:XLEN] : step[2*XLEN-1:XLEN];
        case (op_q)
            OP_MUL:                   fin_res = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU,
            OP_MULHU:                 fin_res = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:          fin_res = quot;
            default:                  fin_res = rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= OP_MUL;
            cnt_q    <= '0;
            rd_q     <= '0;
            acc_q    <= '0;
            m_q      <= '0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            result_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    op_q    <= op_in;
                    rd_q    <= rd_in;
                    cnt_q   <= '0;
                    a_neg_q <= a_neg;
                    b_neg_q <= b_neg;
                    if (div_zero) begin
                        result_q <= funct3[1] ? rs1_val : DIV_ZERO_Q;
                        state_q  <= S_DONE;
                    end else if (div_ovf) begin
                        result_q <= funct3[1] ? '0 : INT_MIN;
                        state_q  <= S_DONE;
                    end else if (funct3[2]) begin
                        acc_q   <= {{XLEN{1'b0}}, a_mag};
                        m_q     <= b_mag;
                        state_q <= S_DIV;
                    end else begin
                        acc_q   <= {{XLEN{1'b0}}, b_mag};
                        m_q     <= a_mag;
                        state_q <= S_MUL;
                    end
                end
                S_MUL, S_DIV: begin
                    acc_q <= step;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        result_q <= fin_res;
                        state_q  <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign rd_out = rd_q;
    assign wb_en  = done && (rd_q != 5'd0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed RV32M vectors, latency, start-ignore and reset abort.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [2:0]  funct3;
    logic [4:0]  rd_in;
    logic [31:0] rs1_val, rs2_val;
    logic        busy, done, wb_en;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .start(start), .funct3(funct3), .rd_in(rd_in),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .busy(busy), .done(done),
        .result(result), .rd_out(rd_out), .wb_en(wb_en)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Raises start just after edge E0, counts edges until done and checks the outcome.
    task automatic do_op(input string tag, input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input int exp_lat, input bit poke);
        int n;
        @(posedge clk); #1;
        funct3 = f3; rd_in = rd; rs1_val = a; rs2_val = b; start = 1'b1;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            n = i;
            if (i == 1) begin
                start = 1'b0;
                funct3 = 3'b101; rs1_val = 32'hDEAD_BEEF; rs2_val = 32'h3; rd_in = 5'd31;
            end
            if (poke && i == 5) begin
                start = 1'b1; funct3 = 3'b101; rs1_val = 32'd1000; rs2_val = 32'd10; rd_in = 5'd9;
            end
            if (poke && i == 8) start = 1'b0;
            if (done) break;
        end
        check({tag, " latency"}, n, exp_lat);
        check({tag, " result"}, result, exp_res);
        check({tag, " rd_out"}, {27'd0, rd_out}, {27'd0, rd});
        check({tag, " wb_en"}, {31'd0, wb_en}, {31'd0, rd != 5'd0});
        @(posedge clk); #1;
        check({tag, " done pulse ends"}, {30'd0, done, busy}, 32'd0);
        check({tag, " result held"}, result, exp_res);
    endtask

    initial begin
        int dcount;
        reset = 1'b1; start = 1'b0; funct3 = '0; rd_in = '0; rs1_val = '0; rs2_val = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset wb_en", {31'd0, wb_en}, 32'd0);
        check("reset result", result, 32'd0);
        check("reset rd_out", {27'd0, rd_out}, 32'd0);
        // Reset wins over a simultaneous start.
        start = 1'b1; funct3 = 3'b101; rs2_val = 32'd0; rs1_val = 32'd5;
        @(posedge clk); #1;
        check("reset beats start", {31'd0, busy}, 32'd0);
        start = 1'b0; reset = 1'b0;

        do_op("MUL",     3'b000, 5'd5, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 0);
        do_op("MULHU",   3'b011, 5'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0);
        do_op("MULH",    3'b001, 5'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, 0);
        do_op("MULHSU",  3'b010, 5'd3, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33, 0);
        do_op("DIV",     3'b100, 5'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, 0);
        do_op("REM",     3'b110, 5'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, 0);
        do_op("DIVU",    3'b101, 5'd7, 32'd100,       32'd7,         32'd14,        33, 0);
        do_op("REMU",    3'b111, 5'd8, 32'd100,       32'd7,         32'd2,         33, 0);
        do_op("DIVU0",   3'b101, 5'd9, 32'd5,         32'd0,         32'hFFFF_FFFF, 1,  0);
        do_op("REMU0",   3'b111, 5'd10, 32'd5,        32'd0,         32'd5,         1,  0);
        do_op("DIVOVF",  3'b100, 5'd11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
        do_op("REMOVF",  3'b110, 5'd12, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0);
        do_op("MULpoke", 3'b000, 5'd0, 32'd7,         32'd3,         32'd21,        33, 1);

        // Reset ten cycles into a divide aborts it without a done pulse.
        @(posedge clk); #1;
        funct3 = 3'b101; rd_in = 5'd13; rs1_val = 32'd100; rs2_val = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("DIV running", {31'd0, busy}, 32'd1);
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        check("abort result", result, 32'd0);
        check("abort rd_out", {27'd0, rd_out}, 32'd0);
        dcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done || busy) dcount++;
        end
        check("abort no done", dcount, 0);
        do_op("after abort", 3'b101, 5'd13, 32'd100, 32'd7, 32'd14, 33, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
